ofmap_write_scheduler: RTL and testbench

Raster-order write sequencer between the systolic array's per-column output FIFOs and the output feature-map memory. On `start` it latches a base address and the feature-map side length `S`. It then pops exactly S×S pixels from the column FIFOs in row-major order, stalling on empty lanes, and issues one memory write per pixel at `initial_address + r*S + c`. It sits downstream of the PE column drain logic and upstream of the ofmap BRAM write port.

---
 rtl/ofmap_write_scheduler.sv | 148 ++++++++++++++
 tb/tb_ofmap_write_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_write_scheduler.sv
// rtl/ofmap_write_scheduler.sv - raster-order ofmap write sequencer
// Pops S*S pixels from per-column FWFT FIFOs in row-major order and issues one memory write per pixel.
module ofmap_write_scheduler #(
  parameter int NUM_COLS   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE_WIDTH = 8
) (
  input  logic                           w_clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           enable,
  input  logic [ADDR_WIDTH-1:0]          initial_address,
  input  logic [SIZE_WIDTH-1:0]          output_featuremapsize,
  input  logic [NUM_COLS-1:0]            is_empty,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_COLS-1:0]            read_enable,
  output logic                           write_enable,
  output logic [ADDR_WIDTH-1:0]          c_address,
  output logic [DATA_WIDTH-1:0]          w_data,
  output logic                           busy,
  output logic                           done
);

  localparam int LANE_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SIZE_WIDTH-1:0]   row_q, row_d;
  logic [SIZE_WIDTH-1:0]   col_q, col_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    lane_empty;
  logic [DATA_WIDTH-1:0]   lane_data;
  logic                    pop;
  logic [SIZE_WIDTH-1:0]   size_m1;
  logic                    last_col;
  logic                    last_row;

  // Lane mux by compare against constant indices so non-power-of-two NUM_COLS never indexes out of range.
  always_comb begin
    lane_empty = 1'b1;
    lane_data  = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      if (lane_q == LANE_W'(j)) begin
        lane_empty = is_empty[j];
        lane_data  = fifo_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign size_m1  = size_q - SIZE_WIDTH'(1);
  assign last_col = (col_q == size_m1);
  assign last_row = (row_q == size_m1);
  assign pop      = (state_q == RUN) && enable && !lane_empty;

  always_comb begin
    read_enable = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      read_enable[j] = pop && (lane_q == LANE_W'(j));
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    lane_d     = lane_q;
    size_d     = size_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d     = output_featuremapsize;
          row_base_d = initial_address;
          row_d      = '0;
          col_d      = '0;
          lane_d     = '0;
          state_d    = (output_featuremapsize == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop) begin
          we_d    = 1'b1;
          addr_d  = row_base_q + ADDR_WIDTH'(col_q);
          wdata_d = lane_data;
          if (last_col) begin
            col_d      = '0;
            lane_d     = '0;
            row_d      = row_q + SIZE_WIDTH'(1);
            row_base_d = row_base_q + ADDR_WIDTH'(size_q);
            if (last_row) state_d = DONE;
          end else begin
            col_d  = col_q + SIZE_WIDTH'(1);
            lane_d = (lane_q == LANE_W'(NUM_COLS - 1)) ? '0 : lane_q + LANE_W'(1);
          end
        end
      end
      DONE: begin
        row_d   = '0;
        col_d   = '0;
        lane_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      row_base_q <= row_base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign write_enable = we_q;
  assign c_address    = addr_q;
  assign w_data       = wdata_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_ofmap_write_scheduler.sv
// tb/tb_ofmap_write_scheduler.sv - directed self-checking bench for ofmap_write_scheduler
// FIFO lanes are modelled as counters: lane j presents j*0x100 + (pops so far on lane j).
module tb_ofmap_write_scheduler;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] init_addr = '0;
  logic [SW-1:0] fsize = '0;
  logic [NC-1:0] is_empty = '0;
  logic [NC*DW-1:0] fifo_data;
  logic [NC-1:0] read_enable;
  logic          write_enable;
  logic [AW-1:0] c_address;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;

  int pass_cnt = 0;
  int total_cnt = 0;

  ofmap_write_scheduler #(.NUM_COLS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .w_clk(clk), .reset(rst_n), .start(start), .enable(enable),
    .initial_address(init_addr), .output_featuremapsize(fsize),
    .is_empty(is_empty), .fifo_data(fifo_data), .read_enable(read_enable),
    .write_enable(write_enable), .c_address(c_address), .w_data(w_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   cnt [NC];
  logic clr = 1'b0;

  always @(posedge clk) begin
    for (int j = 0; j < NC; j++) begin
      if (clr) cnt[j] <= 0;
      else if (read_enable[j]) cnt[j] <= cnt[j] + 1;
    end
  end

  always_comb begin
    fifo_data = '0;
    for (int j = 0; j < NC; j++) fifo_data[j*DW +: DW] = DW'(j*256 + cnt[j]);
  end

  int            cyc = 0;
  logic [NC-1:0] re_log [$];
  logic          busy_log [$];
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            done_cyc [$];
  int            st_cyc [$];
  int            onehot_err = 0;

  always @(negedge clk) begin
    #2;
    cyc++;
    re_log.push_back(read_enable);
    busy_log.push_back(busy);
    if (write_enable) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(c_address);
      wr_data.push_back(w_data);
    end
    if (done) done_cyc.push_back(cyc);
    if (start) st_cyc.push_back(cyc);
    if (read_enable != '0 && !$onehot(read_enable)) onehot_err++;
  end

  task automatic clear_logs();
    re_log.delete(); busy_log.delete(); wr_cyc.delete(); wr_addr.delete();
    wr_data.delete(); done_cyc.delete(); st_cyc.delete(); onehot_err = 0;
  endtask

  // Returns at the negedge of the first RUN cycle; log index 0 is the start cycle.
  task automatic kick(input logic [AW-1:0] base, input logic [SW-1:0] s);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    clear_logs();
    init_addr = base; fsize = s; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (read_enable !== '0) $display("FAIL reset_re: got %h expected 0", read_enable); else pass_cnt++;
    total_cnt++; if (write_enable !== 1'b0) $display("FAIL reset_we: got %b expected 0", write_enable); else pass_cnt++;
    total_cnt++; if (c_address !== '0) $display("FAIL reset_addr: got %h expected 0", c_address); else pass_cnt++;
    total_cnt++; if (w_data !== '0) $display("FAIL reset_data: got %h expected 0", w_data); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int ec [NC];
    logic [DW-1:0] ed;
    int lane;
    foreach (ec[j]) ec[j] = 0;
    kick(10'h010, 8'd3);
    repeat (14) @(negedge clk);
    total_cnt++; if (wr_addr.size() != 9) $display("FAIL basic_count: got %0d expected 9", wr_addr.size()); else pass_cnt++;
    for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
      lane = (i % 3) % NC;
      ed = DW'(lane*256 + ec[lane]);
      ec[lane]++;
      total_cnt++; if (wr_addr[i] !== AW'(10'h010 + i)) $display("FAIL basic_addr%0d: got %h expected %h", i, wr_addr[i], AW'(10'h010 + i)); else pass_cnt++;
      total_cnt++; if (wr_data[i] !== ed) $display("FAIL basic_data%0d: got %h expected %h", i, wr_data[i], ed); else pass_cnt++;
      total_cnt++; if (re_log[i+1] !== NC'(1 << lane)) $display("FAIL basic_lane%0d: got %b expected %b", i, re_log[i+1], NC'(1 << lane)); else pass_cnt++;
    end
    if (wr_cyc.size() == 9) begin
      total_cnt++; if (wr_cyc[0] - st_cyc[0] != 2) $display("FAIL basic_latency: got %0d expected 2", wr_cyc[0] - st_cyc[0]); else pass_cnt++;
      total_cnt++; if (wr_cyc[8] - wr_cyc[0] != 8) $display("FAIL basic_b2b: got %0d expected 8", wr_cyc[8] - wr_cyc[0]); else pass_cnt++;
      total_cnt++; if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[8]) $display("FAIL basic_done: got %0d pulses expected 1 with last write", done_cyc.size()); else pass_cnt++;
    end
    total_cnt++; if (busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) $display("FAIL basic_busy: got %b%b expected 10", busy_log[9], busy_log[10]); else pass_cnt++;
    total_cnt++; if (onehot_err != 0) $display("FAIL basic_onehot: got %0d expected 0", onehot_err); else pass_cnt++;
  endtask

  task automatic test_stall();
    int ec [NC];
    logic [DW-1:0] ed;
    int lane;
    foreach (ec[j]) ec[j] = 0;
    is_empty = 4'b0010;
    kick(10'h010, 8'd5);
    repeat (4) @(negedge clk);
    is_empty = '0;
    repeat (30) @(negedge clk);
    total_cnt++; if (re_log[1] !== 4'b0001) $display("FAIL stall_first: got %b expected 0001", re_log[1]); else pass_cnt++;
    total_cnt++; if ({re_log[2], re_log[3], re_log[4]} !== 12'h000) $display("FAIL stall_hold: got %b%b%b expected 0", re_log[2], re_log[3], re_log[4]); else pass_cnt++;
    total_cnt++; if (re_log[5] !== 4'b0010 || re_log[6] !== 4'b0100) $display("FAIL stall_resume: got %b %b expected 0010 0100", re_log[5], re_log[6]); else pass_cnt++;
    total_cnt++; if (wr_addr.size() != 25) $display("FAIL stall_count: got %0d expected 25", wr_addr.size()); else pass_cnt++;
    if (wr_cyc.size() >= 2) begin
      total_cnt++; if (wr_cyc[1] - wr_cyc[0] != 4 || wr_addr[1] !== 10'h011) $display("FAIL stall_gap: got %0d at %h expected 4 at 011", wr_cyc[1] - wr_cyc[0], wr_addr[1]); else pass_cnt++;
    end
    for (int i = 0; i < 25 && i < wr_addr.size(); i++) begin
      lane = (i % 5) % NC;
      ed = DW'(lane*256 + ec[lane]);
      ec[lane]++;
      total_cnt++; if (wr_addr[i] !== AW'(10'h010 + i) || wr_data[i] !== ed) $display("FAIL stall_wr%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], AW'(10'h010 + i), ed); else pass_cnt++;
    end
  endtask

  task automatic test_enable_gate();
    int zeros;
    int pops;
    kick(10'h100, 8'd4);
    @(negedge clk);
    @(negedge clk); enable = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); enable = 1'b1;
    repeat (20) @(negedge clk);
    total_cnt++; if (re_log[1] == '0 || re_log[2] == '0 || re_log[7] == '0) $display("FAIL en_pops: got %b %b %b expected nonzero", re_log[1], re_log[2], re_log[7]); else pass_cnt++;
    zeros = 0; pops = 0;
    for (int i = 1; i < re_log.size(); i++) begin
      if (re_log[i] != '0) pops++;
      else if (pops > 0 && pops < 16) zeros++;
    end
    total_cnt++; if (zeros != 4) $display("FAIL en_pause: got %0d expected 4", zeros); else pass_cnt++;
    total_cnt++; if (wr_addr.size() != 16) $display("FAIL en_count: got %0d expected 16", wr_addr.size()); else pass_cnt++;
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      total_cnt++; if (wr_addr[i] !== AW'(10'h100 + i)) $display("FAIL en_addr%0d: got %h expected %h", i, wr_addr[i], AW'(10'h100 + i)); else pass_cnt++;
    end
  endtask

  task automatic test_zero_size();
    int nre;
    int nbusy;
    kick(10'h0AA, 8'd0);
    repeat (5) @(negedge clk);
    nre = 0; nbusy = 0;
    foreach (re_log[i]) if (re_log[i] != '0) nre++;
    foreach (busy_log[i]) if (busy_log[i]) nbusy++;
    total_cnt++; if (done_cyc.size() != 1) $display("FAIL zero_done_count: got %0d expected 1", done_cyc.size()); else pass_cnt++;
    if (done_cyc.size() == 1) begin
      total_cnt++; if (done_cyc[0] - st_cyc[0] != 1) $display("FAIL zero_done_time: got %0d expected 1", done_cyc[0] - st_cyc[0]); else pass_cnt++;
    end
    total_cnt++; if (nre != 0 || wr_addr.size() != 0) $display("FAIL zero_activity: got %0d pops %0d writes expected 0 0", nre, wr_addr.size()); else pass_cnt++;
    total_cnt++; if (nbusy != 0) $display("FAIL zero_busy: got %0d expected 0", nbusy); else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [DW-1:0] ed [4] = '{16'h0000, 16'h0100, 16'h0001, 16'h0101};
    kick(10'h3FE, 8'd2);
    repeat (6) @(negedge clk);
    total_cnt++; if (wr_addr.size() != 4) $display("FAIL wrap_count: got %0d expected 4", wr_addr.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      total_cnt++; if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) $display("FAIL wrap_wr%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]); else pass_cnt++;
    end
  endtask

  task automatic test_restart_and_reset();
    kick(10'h020, 8'd3);
    @(negedge clk);
    init_addr = 10'h050; fsize = 8'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    total_cnt++; if (wr_addr.size() != 9) $display("FAIL restart_count: got %0d expected 9", wr_addr.size()); else pass_cnt++;
    for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
      total_cnt++; if (wr_addr[i] !== AW'(10'h020 + i)) $display("FAIL restart_addr%0d: got %h expected %h", i, wr_addr[i], AW'(10'h020 + i)); else pass_cnt++;
    end
    total_cnt++; if (done_cyc.size() != 1 || busy !== 1'b0) $display("FAIL restart_done: got %0d pulses busy %b expected 1 0", done_cyc.size(), busy); else pass_cnt++;

    kick(10'h030, 8'd3);
    repeat (5) @(negedge clk);
    total_cnt++; if (write_enable !== 1'b1 || busy !== 1'b1) $display("FAIL rst_pre: got we %b busy %b expected 1 1", write_enable, busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({read_enable, write_enable, busy, done} !== '0) $display("FAIL rst_async_ctl: got %b expected 0", {read_enable, write_enable, busy, done}); else pass_cnt++;
    total_cnt++; if (c_address !== '0 || w_data !== '0) $display("FAIL rst_async_dp: got %h/%h expected 0/0", c_address, w_data); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    kick(10'h030, 8'd3);
    repeat (12) @(negedge clk);
    total_cnt++; if (wr_addr.size() != 9) $display("FAIL rst_fresh_count: got %0d expected 9", wr_addr.size()); else pass_cnt++;
    if (wr_addr.size() > 0) begin
      total_cnt++; if (wr_addr[0] !== 10'h030 || wr_data[0] !== 16'h0000) $display("FAIL rst_fresh_first: got %h/%h expected 030/0000", wr_addr[0], wr_data[0]); else pass_cnt++;
      total_cnt++; if (wr_addr[wr_addr.size()-1] !== 10'h038) $display("FAIL rst_fresh_last: got %h expected 038", wr_addr[wr_addr.size()-1]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_enable_gate();
    test_zero_size();
    test_addr_wrap();
    test_restart_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
